// File: rtl/bc_stage_id.sv
// bc_stage_id: RV32I instruction-decode stage.
// Decodes the fetched instruction (or the skid entry) into registered control
// fields for execute, with a one-entry skid buffer that absorbs the instruction
// already in flight when execute stalls.
//
// Handshake: fetch presents i_instr/i_pc qualified by i_instr_valid and must not
// present a new valid while o_if_stall is high (such a valid is ignored). Execute
// accepts the output register on every edge where i_stall is low; while i_stall
// is high every output holds. i_flush kills both the output register and the skid
// entry on the next edge and beats stall and new input.
module bc_stage_id #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int INSTR_WIDTH = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rstn,
    input  logic                   i_instr_valid,
    input  logic [INSTR_WIDTH-1:0] i_instr,
    input  logic [ADDR_WIDTH-1:0]  i_pc,
    input  logic                   i_stall,
    input  logic                   i_flush,
    output logic                   o_if_stall,
    output logic                   o_valid,
    output logic [ADDR_WIDTH-1:0]  o_pc,
    output logic [4:0]             o_rs1_addr,
    output logic [4:0]             o_rs2_addr,
    output logic [4:0]             o_rd_addr,
    output logic                   o_rd_wen,
    output logic [DATA_WIDTH-1:0]  o_imm,
    output logic [3:0]             o_alu_op,
    output logic                   o_alu_src_imm,
    output logic                   o_alu_src_pc,
    output logic [2:0]             o_funct3,
    output logic                   o_mem_ren,
    output logic                   o_mem_wen,
    output logic                   o_branch,
    output logic                   o_jump,
    output logic                   o_illegal
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_SLL    = 4'd2;
    localparam logic [3:0] ALU_SLT    = 4'd3;
    localparam logic [3:0] ALU_SLTU   = 4'd4;
    localparam logic [3:0] ALU_XOR    = 4'd5;
    localparam logic [3:0] ALU_SRL    = 4'd6;
    localparam logic [3:0] ALU_SRA    = 4'd7;
    localparam logic [3:0] ALU_OR     = 4'd8;
    localparam logic [3:0] ALU_AND    = 4'd9;
    localparam logic [3:0] ALU_PASS_B = 4'd10;

    // funct3 -> ALU operation; alt selects SUB / SRA (instr[30])
    function automatic logic [3:0] alu_sel(input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0:    alu_sel = alt ? ALU_SUB : ALU_ADD;
            3'd1:    alu_sel = ALU_SLL;
            3'd2:    alu_sel = ALU_SLT;
            3'd3:    alu_sel = ALU_SLTU;
            3'd4:    alu_sel = ALU_XOR;
            3'd5:    alu_sel = alt ? ALU_SRA : ALU_SRL;
            3'd6:    alu_sel = ALU_OR;
            default: alu_sel = ALU_AND;
        endcase
    endfunction

    logic                   skid_valid;
    logic [INSTR_WIDTH-1:0] skid_instr;
    logic [ADDR_WIDTH-1:0]  skid_pc;

    logic                   src_valid;
    logic [31:0]            src_instr;
    logic [ADDR_WIDTH-1:0]  src_pc;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] d_imm;
    logic [3:0]  d_alu_op;
    logic        d_rd_wen;
    logic        d_src_imm;
    logic        d_src_pc;
    logic        d_mem_ren;
    logic        d_mem_wen;
    logic        d_branch;
    logic        d_jump;
    logic        d_illegal;

    // The skid entry, when present, always goes ahead of the fetch input.
    assign src_valid  = skid_valid | i_instr_valid;
    assign src_instr  = skid_valid ? skid_instr[31:0] : i_instr[31:0];
    assign src_pc     = skid_valid ? skid_pc : i_pc;
    assign o_if_stall = skid_valid;

    assign opcode = src_instr[6:0];
    assign funct3 = src_instr[14:12];
    assign funct7 = src_instr[31:25];

    // Combinational RV32I decode of the selected source instruction
    always_comb begin
        d_imm     = '0;
        d_alu_op  = ALU_ADD;
        d_rd_wen  = 1'b0;
        d_src_imm = 1'b0;
        d_src_pc  = 1'b0;
        d_mem_ren = 1'b0;
        d_mem_wen = 1'b0;
        d_branch  = 1'b0;
        d_jump    = 1'b0;
        d_illegal = 1'b0;
        case (opcode)
            OPC_LUI: begin
                d_imm = {src_instr[31:12], 12'b0};
                d_alu_op = ALU_PASS_B; d_src_imm = 1'b1; d_rd_wen = 1'b1;
            end
            OPC_AUIPC: begin
                d_imm = {src_instr[31:12], 12'b0};
                d_src_imm = 1'b1; d_src_pc = 1'b1; d_rd_wen = 1'b1;
            end
            OPC_JAL: begin
                d_imm = {{12{src_instr[31]}}, src_instr[19:12], src_instr[20], src_instr[30:21], 1'b0};
                d_src_imm = 1'b1; d_src_pc = 1'b1; d_jump = 1'b1; d_rd_wen = 1'b1;
            end
            OPC_JALR: begin
                d_imm = {{20{src_instr[31]}}, src_instr[31:20]};
                d_src_imm = 1'b1; d_jump = 1'b1; d_rd_wen = 1'b1;
                d_illegal = (funct3 != 3'd0);
            end
            OPC_BRANCH: begin
                d_imm = {{20{src_instr[31]}}, src_instr[7], src_instr[30:25], src_instr[11:8], 1'b0};
                d_src_imm = 1'b1; d_src_pc = 1'b1; d_branch = 1'b1;
                d_illegal = (funct3 == 3'd2) || (funct3 == 3'd3);
            end
            OPC_LOAD: begin
                d_imm = {{20{src_instr[31]}}, src_instr[31:20]};
                d_src_imm = 1'b1; d_mem_ren = 1'b1; d_rd_wen = 1'b1;
                d_illegal = (funct3 == 3'd3) || (funct3 >= 3'd6);
            end
            OPC_STORE: begin
                d_imm = {{20{src_instr[31]}}, src_instr[31:25], src_instr[11:7]};
                d_src_imm = 1'b1; d_mem_wen = 1'b1;
                d_illegal = (funct3 > 3'd2);
            end
            OPC_OPIMM: begin
                // instr[30] only means SRAI for the right shift; ADDI has no SUB form
                d_imm = {{20{src_instr[31]}}, src_instr[31:20]};
                d_alu_op = alu_sel(funct3, (funct3 == 3'd5) && src_instr[30]);
                d_src_imm = 1'b1; d_rd_wen = 1'b1;
                d_illegal = ((funct3 == 3'd1) && (funct7 != 7'h00)) ||
                            ((funct3 == 3'd5) && (funct7 != 7'h00) && (funct7 != 7'h20));
            end
            OPC_OP: begin
                d_alu_op = alu_sel(funct3, src_instr[30]);
                d_rd_wen = 1'b1;
                d_illegal = (funct7 != 7'h00) &&
                            !((funct7 == 7'h20) && ((funct3 == 3'd0) || (funct3 == 3'd5)));
            end
            default: d_illegal = 1'b1;
        endcase
        if (d_illegal) begin
            d_imm     = '0;
            d_alu_op  = ALU_ADD;
            d_rd_wen  = 1'b0;
            d_src_imm = 1'b0;
            d_src_pc  = 1'b0;
            d_mem_ren = 1'b0;
            d_mem_wen = 1'b0;
            d_branch  = 1'b0;
            d_jump    = 1'b0;
        end
        if (src_instr[11:7] == 5'd0) begin
            d_rd_wen = 1'b0;
        end
    end

    // Skid entry: fill on stall when empty, drain on release, kill on flush.
    // A valid arriving during a stall is kept even if the output is empty, so
    // nothing fetch hands over is ever dropped.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            skid_valid <= 1'b0;
            skid_instr <= '0;
            skid_pc    <= '0;
        end else if (i_flush) begin
            skid_valid <= 1'b0;
        end else if (i_stall) begin
            if (!skid_valid && i_instr_valid) begin
                skid_valid <= 1'b1;
                skid_instr <= i_instr;
                skid_pc    <= i_pc;
            end
        end else begin
            skid_valid <= 1'b0;
        end
    end

    // Output register: loads the decoded source whenever execute is not stalled
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_valid       <= 1'b0;
            o_pc          <= '0;
            o_rs1_addr    <= '0;
            o_rs2_addr    <= '0;
            o_rd_addr     <= '0;
            o_rd_wen      <= 1'b0;
            o_imm         <= '0;
            o_alu_op      <= '0;
            o_alu_src_imm <= 1'b0;
            o_alu_src_pc  <= 1'b0;
            o_funct3      <= '0;
            o_mem_ren     <= 1'b0;
            o_mem_wen     <= 1'b0;
            o_branch      <= 1'b0;
            o_jump        <= 1'b0;
            o_illegal     <= 1'b0;
        end else if (i_flush) begin
            o_valid <= 1'b0;
        end else if (!i_stall) begin
            o_valid       <= src_valid;
            o_pc          <= src_pc;
            o_rs1_addr    <= src_instr[19:15];
            o_rs2_addr    <= src_instr[24:20];
            o_rd_addr     <= src_instr[11:7];
            o_rd_wen      <= d_rd_wen;
            o_imm         <= DATA_WIDTH'($signed(d_imm));
            o_alu_op      <= d_alu_op;
            o_alu_src_imm <= d_src_imm;
            o_alu_src_pc  <= d_src_pc;
            o_funct3      <= funct3;
            o_mem_ren     <= d_mem_ren;
            o_mem_wen     <= d_mem_wen;
            o_branch      <= d_branch;
            o_jump        <= d_jump;
            o_illegal     <= d_illegal;
        end
    end

endmodule
